// File: rtl/pipe_stage_skid.sv
// Flow-controlled pipeline stage register with a 2-entry skid buffer, synchronous flush
// and a saturating count of entries discarded by flush.
module pipe_stage_skid #(
    parameter int unsigned        DATA_W      = 128,
    parameter int unsigned        CTRL_W      = 16,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter int unsigned        CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, skid_data_q;
    logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic                acc, fire;
    logic                main_load, main_from_skid, skid_load;
    logic [2:0]          drop_inc;
    logic [CNT_W+1:0]    drop_sum;

    // in_ready and out_valid come straight from the state register.
    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign acc       = in_valid & in_ready;
    assign fire      = out_valid & out_ready;
    assign occupancy = state_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;
    assign drop_cnt  = drop_cnt_q;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (acc) begin
                    state_d   = StOne;
                    main_load = 1'b1;
                end
            end
            StOne: begin
                if (acc && fire) begin
                    main_load = 1'b1;
                end else if (acc) begin
                    state_d   = StTwo;
                    skid_load = 1'b1;
                end else if (fire) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (fire) begin
                    state_d        = StOne;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d        = StEmpty;
            main_load      = 1'b0;
            main_from_skid = 1'b0;
            skid_load      = 1'b0;
        end
    end

    // Held entries not consumed this cycle plus the discarded input; occupancy >= fire always.
    always_comb begin
        drop_inc   = {1'b0, state_q} - {2'b00, fire} + {2'b00, acc};
        drop_sum   = {2'b00, drop_cnt_q} + (CNT_W + 2)'(drop_inc);
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            drop_cnt_d = (drop_sum[CNT_W+1:CNT_W] != 2'b00) ? {CNT_W{1'b1}}
                                                              : drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_BUBBLE;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
            if (main_load) begin
                main_data_q <= in_data;
                main_ctrl_q <= in_ctrl;
            end else if (main_from_skid) begin
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
            end
            if (skid_load) begin
                skid_data_q <= in_data;
                skid_ctrl_q <= in_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid; a second narrow-counter instance
// shares the stimulus to exercise drop_cnt saturation.
module tb_pipe_stage_skid;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_data;
    logic [15:0]   in_ctrl;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic [15:0]   out_ctrl;
    logic [1:0]    occupancy;
    logic [15:0]   drop_cnt;

    logic          d2_in_ready;
    logic          d2_out_valid;
    logic [7:0]    d2_out_data;
    logic [15:0]   d2_out_ctrl;
    logic [1:0]    d2_occupancy;
    logic [1:0]    d2_drop_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy),
        .drop_cnt  (drop_cnt)
    );

    pipe_stage_skid #(
        .DATA_W (8),
        .CNT_W  (2)
    ) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (d2_in_ready),
        .in_data   (in_data[7:0]),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (d2_out_valid),
        .out_ready (out_ready),
        .out_data  (d2_out_data),
        .out_ctrl  (d2_out_ctrl),
        .occupancy (d2_occupancy),
        .drop_cnt  (d2_drop_cnt)
    );

    task automatic drive(input logic v, input logic [127:0] d, input logic [15:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0);
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, occupancy} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_flags: got v/r/occ=%b want 0100", {out_valid, in_ready, occupancy});
        end
        checks++;
        if (out_data !== 128'd0 || out_ctrl !== 16'd0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: got data=%0h ctrl=%0h drop=%0d want 0 0 0",
                     out_data, out_ctrl, drop_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_streaming();
        logic ready_seen_low = 1'b0;
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!in_ready) ready_seen_low = 1'b1;
            if (k > 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 128'(k - 1) || out_ctrl !== 16'(k - 1)
                    || occupancy !== 2'd1) begin
                    errors++;
                    $display("FAIL stream_%0d: got v=%b data=%0h ctrl=%0h occ=%0d want 1 %0h %0h 1",
                             k - 1, out_valid, out_data, out_ctrl, occupancy, k - 1, k - 1);
                end
            end
            drive(1'b1, 128'(k), 16'(k));
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 128'd8 || out_ctrl !== 16'd8) begin
            errors++;
            $display("FAIL stream_8: got v=%b data=%0h ctrl=%0h want 1 8 8",
                     out_valid, out_data, out_ctrl);
        end
        drive(1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 16'd0 || ready_seen_low) begin
            errors++;
            $display("FAIL stream_drain: got v=%b occ=%0d ctrl=%0h ready_dropped=%b want 0 0 0 0",
                     out_valid, occupancy, out_ctrl, ready_seen_low);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 128'hA, 16'h00A);
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 128'hA) begin
            errors++;
            $display("FAIL stall_one: got occ=%0d rdy=%b data=%0h want 1 1 a",
                     occupancy, in_ready, out_data);
        end
        drive(1'b1, 128'hB, 16'h00B);
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 128'hA
            || out_ctrl !== 16'h00A) begin
            errors++;
            $display("FAIL stall_two: got occ=%0d rdy=%b data=%0h ctrl=%0h want 2 0 a a",
                     occupancy, in_ready, out_data, out_ctrl);
        end
        // Full stage must refuse a third entry while stalled.
        drive(1'b1, 128'hC, 16'h00C);
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd2 || out_data !== 128'hA) begin
            errors++;
            $display("FAIL stall_hold: got occ=%0d data=%0h want 2 a", occupancy, out_data);
        end
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 128'hB
            || out_ctrl !== 16'h00B) begin
            errors++;
            $display("FAIL stall_drain_b: got occ=%0d rdy=%b data=%0h ctrl=%0h want 1 1 b b",
                     occupancy, in_ready, out_data, out_ctrl);
        end
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_empty: got occ=%0d rdy=%b v=%b want 0 1 0",
                     occupancy, in_ready, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush_two();
        drive(1'b1, 128'hC1, 16'h0C1);
        @(negedge clk);
        drive(1'b1, 128'hD1, 16'h0D1);
        @(negedge clk);
        drive(1'b1, 128'hE1, 16'h0E1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, '0, '0);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'd0 || occupancy !== 2'd0
            || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_two_state: got v=%b ctrl=%0h occ=%0d rdy=%b want 0 0 0 1",
                     out_valid, out_ctrl, occupancy, in_ready);
        end
        checks++;
        if (drop_cnt !== 16'd2 || out_data !== 128'hC1) begin
            errors++;
            $display("FAIL flush_two_count: got drop=%0d data=%0h want 2 c1", drop_cnt, out_data);
        end
    endtask

    task automatic test_flush_one();
        drive(1'b1, 128'hF1, 16'h0F1);
        @(negedge clk);
        drive(1'b1, 128'h61, 16'h061);
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, '0, '0);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || drop_cnt !== 16'd3) begin
            errors++;
            $display("FAIL flush_one: got v=%b occ=%0d drop=%0d want 0 0 3",
                     out_valid, occupancy, drop_cnt);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || drop_cnt !== 16'd3) begin
            errors++;
            $display("FAIL flush_one_no_leak: got v=%b drop=%0d want 0 3", out_valid, drop_cnt);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        checks++;
        if (d2_drop_cnt !== 2'd0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL sat_clear: got narrow=%0d wide=%0d want 0 0", d2_drop_cnt, drop_cnt);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drive(1'b1, 128'(i), 16'(i));
            @(negedge clk);
            drive(1'b1, 128'(i + 16), 16'(i + 16));
            @(negedge clk);
            drive(1'b0, '0, '0);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            checks++;
            if (d2_drop_cnt !== ((i == 1) ? 2'd2 : 2'd3) || drop_cnt !== 16'(2 * i)) begin
                errors++;
                $display("FAIL sat_flush_%0d: got narrow=%0d wide=%0d want %0d %0d",
                         i, d2_drop_cnt, drop_cnt, (i == 1) ? 2 : 3, 2 * i);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1'b1, 128'h71, 16'h071);
        @(negedge clk);
        drive(1'b1, 128'h72, 16'h072);
        @(negedge clk);
        drive(1'b0, '0, '0);
        checks++;
        if (occupancy !== 2'd2) begin
            errors++;
            $display("FAIL areset_prefill: got occ=%0d want 2", occupancy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, occupancy} !== 4'b0100 || out_data !== 128'd0
            || out_ctrl !== 16'd0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL areset_immediate: got v/r/occ=%b data=%0h ctrl=%0h drop=%0d want 0100 0 0 0",
                     {out_valid, in_ready, occupancy}, out_data, out_ctrl, drop_cnt);
        end
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 128'h81, 16'h081);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 128'h81 || out_ctrl !== 16'h081) begin
            errors++;
            $display("FAIL areset_resume_1: got v=%b data=%0h ctrl=%0h want 1 81 81",
                     out_valid, out_data, out_ctrl);
        end
        drive(1'b1, 128'h82, 16'h082);
        @(negedge clk);
        drive(1'b0, '0, '0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 128'h82 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL areset_resume_2: got v=%b data=%0h occ=%0d want 1 82 1",
                     out_valid, out_data, occupancy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL areset_drain: got v=%b drop=%0d want 0 0", out_valid, drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_flush_two();
        test_flush_one();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
